writeback_arbiter: RTL and testbench

Write-side initiator for the CPU register file. It accepts completed results from the single-cycle ALU path and the multi-cycle load/store unit (LSU), buffers ALU results in a small in-order FIFO, and arbitrates them onto the register file's single write port. The write port is driven from registers. It also exports a pending-write bitmap that issue logic uses for RAW/WAW hazard checks.

---
 rtl/writeback_arbiter.sv | 160 ++++++++++++++++
 tb/tb_writeback_arbiter.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// +----------------------------------------------------------------------------+
// | writeback_arbiter: merges ALU (FIFO-buffered) and LSU results onto the    |
// | register-file write port. Optional macro: WB_ALU_BYPASS_EN.               |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module writeback_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2,
  localparam int NUM_WORDS = 2 ** ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  alu_valid_i,
  output logic                  alu_ready_o,
  input  logic [ADDR_WIDTH-1:0] alu_waddr_i,
  input  logic [DATA_WIDTH-1:0] alu_wdata_i,
  input  logic                  lsu_valid_i,
  output logic                  lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_a_o,
  output logic [NUM_WORDS-1:0]  pending_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] C_DEPTH   = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] C_PTR_MAX = PTR_W'(FIFO_DEPTH - 1);

  logic [ADDR_WIDTH-1:0] waddr_mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] waddr_mem_d [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] wdata_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] wdata_mem_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  we_q, we_d;

  logic fifo_full, fifo_empty;
  logic sel_lsu, sel_fifo, sel_byp, enq, deq;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == C_PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full   = (count_q == C_DEPTH);
  assign fifo_empty  = (count_q == '0);
  assign alu_ready_o = !fifo_full;
  assign lsu_ready_o = !fifo_full;

`ifdef WB_ALU_BYPASS_EN
  assign sel_byp = fifo_empty && !lsu_valid_i && alu_valid_i;
`else
  assign sel_byp = 1'b0;
`endif

  // A full FIFO wins over the LSU so the ALU stream can never be starved.
  assign sel_lsu  = !fifo_full && lsu_valid_i;
  assign sel_fifo = fifo_full || (!lsu_valid_i && !fifo_empty);
  assign enq      = alu_valid_i && alu_ready_o && !sel_byp;
  assign deq      = sel_fifo;

  always_comb begin
    sel_addr = alu_waddr_i;
    sel_data = alu_wdata_i;
    if (sel_lsu) begin
      sel_addr = lsu_waddr_i;
      sel_data = lsu_wdata_i;
    end else if (sel_fifo) begin
      sel_addr = waddr_mem_q[rd_ptr_q];
      sel_data = wdata_mem_q[rd_ptr_q];
    end
  end

  always_comb begin
    waddr_mem_d = waddr_mem_q;
    wdata_mem_d = wdata_mem_q;
    valid_d     = valid_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    we_d        = 1'b0;

    if (deq) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = ptr_inc(rd_ptr_q);
    end
    if (enq) begin
      waddr_mem_d[wr_ptr_q] = alu_waddr_i;
      wdata_mem_d[wr_ptr_q] = alu_wdata_i;
      valid_d[wr_ptr_q]     = 1'b1;
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (enq && !deq) begin
      count_d = count_q + 1'b1;
    end else if (!enq && deq) begin
      count_d = count_q - 1'b1;
    end

    if (sel_lsu || sel_fifo || sel_byp) begin
      waddr_d = sel_addr;
      wdata_d = sel_data;
      we_d    = |sel_addr;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        waddr_mem_q[i] <= '0;
        wdata_mem_q[i] <= '0;
      end
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
    end else begin
      waddr_mem_q <= waddr_mem_d;
      wdata_mem_q <= wdata_mem_d;
      valid_q     <= valid_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      we_q        <= we_d;
    end
  end

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (valid_q[i]) begin
        pending_o[waddr_mem_q[i]] = 1'b1;
      end
    end
    pending_o[0] = 1'b0;
  end

  assign waddr_a_o = waddr_q;
  assign wdata_a_o = wdata_q;
  assign we_a_o    = we_q;

endmodule

`default_nettype wire

// File: tb/tb_writeback_arbiter.sv
// +----------------------------------------------------------------------------+
// | tb_writeback_arbiter: directed scoreboard bench for writeback_arbiter.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_writeback_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        alu_valid_i, lsu_valid_i;
  logic        alu_ready_o, lsu_ready_o;
  logic [4:0]  alu_waddr_i, lsu_waddr_i, waddr_a_o;
  logic [31:0] alu_wdata_i, lsu_wdata_i, wdata_a_o;
  logic        we_a_o;
  logic [31:0] pending_o;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];

  writeback_arbiter #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .FIFO_DEPTH(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .alu_valid_i(alu_valid_i), .alu_ready_o(alu_ready_o),
    .alu_waddr_i(alu_waddr_i), .alu_wdata_i(alu_wdata_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o), .we_a_o(we_a_o),
    .pending_o(pending_o)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: every asserted write must match the head of the expected queue.
  always @(negedge clk_i) begin
    if (we_a_o === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got x%0d=%h, expected no write", waddr_a_o, wdata_a_o);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (waddr_a_o !== e.addr || wdata_a_o !== e.data) begin
          miscompares++;
          $display("FAIL write_order: got x%0d=%h, expected x%0d=%h",
                   waddr_a_o, wdata_a_o, e.addr, e.data);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    alu_valid_i = av; alu_waddr_i = aa; alu_wdata_i = ad;
    lsu_valid_i = lv; lsu_waddr_i = la; lsu_wdata_i = ld;
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    rst_i = 1'b1;
    drive(1, 5'd31, 32'hAAAA_0001, 1, 5'd30, 32'hBBBB_0002);
    tick(); tick();
    chk("reset_we", 64'(we_a_o), 64'd0);
    chk("reset_pending", 64'(pending_o), 64'd0);
    chk("reset_waddr", 64'(waddr_a_o), 64'd0);
    chk("reset_wdata", 64'(wdata_a_o), 64'd0);
    rst_i = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    chk("post_reset_alu_ready", 64'(alu_ready_o), 64'd1);
    chk("post_reset_lsu_ready", 64'(lsu_ready_o), 64'd1);
    tick();

    // Single ALU write to x5
    drive(1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0);
    push(5'd5, 32'hDEAD_BEEF);
    tick();
    drive(0, 0, 0, 0, 0, 0);
`ifdef WB_ALU_BYPASS_EN
    chk("bypass_pending", 64'(pending_o), 64'd0);
    chk("bypass_we", 64'(we_a_o), 64'd1);
    tick();
`else
    chk("alu_pending5", 64'(pending_o), 64'h20);
    chk("alu_we_not_yet", 64'(we_a_o), 64'd0);
    tick();
    chk("alu_we", 64'(we_a_o), 64'd1);
    chk("alu_waddr", 64'(waddr_a_o), 64'd5);
`endif
    tick(); tick();

    // LSU priority over a buffered ALU entry
    drive(1, 5'd3, 32'h11, 1, 5'd20, 32'h20);
    push(5'd20, 32'h20);
    tick();
    drive(0, 0, 0, 1, 5'd7, 32'h22);
    chk("prio_pending3", 64'(pending_o), 64'h8);
    chk("prio_lsu_ready", 64'(lsu_ready_o), 64'd1);
    push(5'd7, 32'h22);
    push(5'd3, 32'h11);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();

    // Full FIFO back-pressure
    drive(1, 5'd1, 32'd1, 1, 5'd10, 32'h10);
    push(5'd10, 32'h10);
    tick();
    drive(1, 5'd2, 32'd2, 1, 5'd11, 32'h11);
    push(5'd11, 32'h11);
    tick();
    drive(0, 0, 0, 1, 5'd9, 32'd9);
    chk("full_lsu_ready", 64'(lsu_ready_o), 64'd0);
    chk("full_alu_ready", 64'(alu_ready_o), 64'd0);
    chk("full_pending", 64'(pending_o), 64'h6);
    push(5'd1, 32'd1);
    tick();
    chk("drain_lsu_ready", 64'(lsu_ready_o), 64'd1);
    push(5'd9, 32'd9);
    push(5'd2, 32'd2);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();

    // x0 filtering
    drive(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0);
    chk("x0_alu_ready", 64'(alu_ready_o), 64'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("x0_pending", 64'(pending_o), 64'd0);
    chk("x0_alu_ready_after", 64'(alu_ready_o), 64'd1);
    tick(); tick();
    chk("x0_we", 64'(we_a_o), 64'd0);
    chk("x0_waddr", 64'(waddr_a_o), 64'd0);
    chk("x0_wdata", 64'(wdata_a_o), 64'hFFFF_FFFF);

    // Reset mid-operation discards x4 and x6
    drive(1, 5'd4, 32'h44, 1, 5'd12, 32'h12);
    push(5'd12, 32'h12);
    tick();
    drive(1, 5'd6, 32'h66, 1, 5'd13, 32'h13);
    push(5'd13, 32'h13);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    chk("midrst_pending_before", 64'(pending_o), 64'h50);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("midrst_pending_after", 64'(pending_o), 64'd0);
    chk("midrst_we", 64'(we_a_o), 64'd0);
    chk("midrst_alu_ready", 64'(alu_ready_o), 64'd1);
    repeat (6) tick();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("all_writes_seen", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
